// File: rtl/vga_rx_pkg.sv
// ============================================================================
// Module      : vga_rx_pkg
// Description : Shared timing defaults, lock-state encoding, PMOD pin indices
//               and CRC constants for the VGA capture monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_rx_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // Tiny VGA PMOD pin order
  localparam int PMOD_R1 = 0;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_VS = 3;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_HS = 7;

  // Both syncs deasserted, colour black
  localparam logic [7:0] SYNC_IDLE = 8'h88;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/vga_crc16_step.sv
// ============================================================================
// Module      : vga_crc16_step
// Description : Combinational CRC-16/CCITT update over one RGB222 pixel,
//               bits shifted MSB-first (R1 first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_crc16_step (
  input  logic [15:0] crc_in,
  input  logic [5:0]  data,
  output logic [15:0] crc_out
);
  import vga_rx_pkg::*;

  logic [15:0] acc;

  always_comb begin
    acc = crc_in;
    for (int i = 5; i >= 0; i--) begin
      if (acc[15] ^ data[i]) begin
        acc = {acc[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        acc = {acc[14:0], 1'b0};
      end
    end
  end

  assign crc_out = acc;

endmodule

`default_nettype wire

// File: rtl/vga_capture_monitor.sv
// ============================================================================
// Module      : vga_capture_monitor
// Description : Recovers pixel coordinates and colour from a Tiny VGA PMOD
//               bus, tracks lock to the expected timing and captures a probe
//               pixel. Per-frame CRC is built only when VGA_CRC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_capture_monitor #(
  parameter int H_ACTIVE = vga_rx_pkg::DEF_H_ACTIVE,
  parameter int H_TOTAL  = vga_rx_pkg::DEF_H_TOTAL,
  parameter int H_BACK   = vga_rx_pkg::DEF_H_BACK,
  parameter int V_ACTIVE = vga_rx_pkg::DEF_V_ACTIVE,
  parameter int V_TOTAL  = vga_rx_pkg::DEF_V_TOTAL,
  parameter int V_BACK   = vga_rx_pkg::DEF_V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_in,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  rgb,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic [5:0]  probe_rgb,
  output logic        probe_hit,
  output logic [7:0]  err_count
);
  import vga_rx_pkg::*;

  localparam logic [9:0]  H_BACK_W  = 10'(H_BACK);
  localparam logic [9:0]  H_END_W   = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_BACK_W  = 10'(V_BACK);
  localparam logic [9:0]  V_END_W   = 10'(V_BACK + V_ACTIVE);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);

  logic [7:0] s1_q;
  // Only the sync bits of the previous sample are needed for edge detection
  logic [1:0] s2_q;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  rx_state_e  state_q, state_d;
  logic       line_err_q, line_err_d;
  logic [7:0] err_q, err_d;
  logic       locked_q, pix_valid_q, pix_valid_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0] rgb_q, rgb_d;
  logic       frame_done_q, frame_done_d;
  logic [5:0] probe_rgb_q, probe_rgb_d;
  logic       probe_hit_q, probe_hit_d;

  logic hs_edge, vs_edge, line_bad, frame_good, active;

  always_comb begin
    hs_edge    = ~s2_q[1] & s1_q[PMOD_HS];
    vs_edge    = ~s2_q[0] & s1_q[PMOD_VS];
    line_bad   = hs_edge && (({1'b0, hcnt_q} + 11'd1) != H_TOTAL_W);
    frame_good = vs_edge && (vcnt_q == V_TOTAL_W) && !line_bad;

    hcnt_d = hs_edge ? 10'd0 : ((&hcnt_q) ? hcnt_q : hcnt_q + 10'd1);
    if (vs_edge) begin
      vcnt_d = 10'd0;
    end else if (hs_edge) begin
      vcnt_d = vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end

    state_d      = state_q;
    line_err_d   = line_err_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d    = TRACK;
          line_err_d = 1'b0;
        end
      end
      TRACK: begin
        if (line_bad) begin
          line_err_d = 1'b1;
        end
        // Every VSYNC edge closes a candidate frame and starts the next one
        if (vs_edge) begin
          if (frame_good && !line_err_q) begin
            state_d = LOCKED;
          end
          line_err_d = 1'b0;
        end
      end
      LOCKED: begin
        if (line_bad || (vs_edge && !frame_good)) begin
          state_d = SEARCH;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end else if (vs_edge) begin
          frame_done_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    pix_x_d = hcnt_d - H_BACK_W;
    pix_y_d = vcnt_d - V_BACK_W;
    active  = (hcnt_d >= H_BACK_W) && (hcnt_d < H_END_W) &&
              (vcnt_d >= V_BACK_W) && (vcnt_d < V_END_W);
    pix_valid_d = (state_d == LOCKED) && active;
    rgb_d = {s1_q[PMOD_R1], s1_q[PMOD_R0], s1_q[PMOD_G1],
             s1_q[PMOD_G0], s1_q[PMOD_B1], s1_q[PMOD_B0]};

    probe_hit_d = pix_valid_d && (pix_x_d == probe_x) && (pix_y_d == probe_y);
    probe_rgb_d = probe_hit_d ? rgb_d : probe_rgb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= SYNC_IDLE;
      s2_q         <= 2'b11;
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      state_q      <= SEARCH;
      line_err_q   <= 1'b0;
      err_q        <= 8'd0;
      locked_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 10'd0;
      pix_y_q      <= 10'd0;
      rgb_q        <= 6'd0;
      frame_done_q <= 1'b0;
      probe_rgb_q  <= 6'd0;
      probe_hit_q  <= 1'b0;
    end else begin
      s1_q         <= vga_in;
      s2_q         <= {s1_q[PMOD_HS], s1_q[PMOD_VS]};
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      state_q      <= state_d;
      line_err_q   <= line_err_d;
      err_q        <= err_d;
      locked_q     <= (state_d == LOCKED);
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
      probe_rgb_q  <= probe_rgb_d;
      probe_hit_q  <= probe_hit_d;
    end
  end

`ifdef VGA_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;
  logic [15:0] frame_crc_q, frame_crc_d;

  vga_crc16_step u_crc_step (
    .crc_in  (crc_q),
    .data    (rgb_d),
    .crc_out (crc_next)
  );

  // Latch happens before the VSYNC restart, so the closed frame is captured
  always_comb begin
    frame_crc_d = frame_done_d ? crc_q : frame_crc_q;
    if (vs_edge) begin
      crc_d = CRC_INIT;
    end else if (pix_valid_d) begin
      crc_d = crc_next;
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= CRC_INIT;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = CRC_INIT;
`endif

  assign locked     = locked_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign rgb        = rgb_q;
  assign frame_done = frame_done_q;
  assign probe_rgb  = probe_rgb_q;
  assign probe_hit  = probe_hit_q;
  assign err_count  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_capture_monitor.sv
// ============================================================================
// Module      : tb_vga_capture_monitor
// Description : Self-checking bench for vga_capture_monitor driven by a small
//               VGA raster generator; frame CRC checked when VGA_CRC_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_capture_monitor;

  localparam int HA = 16, HFP = 2, HSW = 6, HBP = 8;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 8, VFP = 2, VSW = 2, VBP = 3;
  localparam int VT = VA + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  vga_in = 8'h88;
  logic [9:0]  probe_x = 10'd0;
  logic [9:0]  probe_y = 10'd0;
  logic        locked, pix_valid, frame_done, probe_hit;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  rgb, probe_rgb;
  logic [15:0] frame_crc;
  logic [7:0]  err_count;

  vga_capture_monitor #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_BACK(HBP),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_BACK(VBP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_in     (vga_in),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rgb        (rgb),
    .frame_done (frame_done),
    .frame_crc  (frame_crc),
    .probe_rgb  (probe_rgb),
    .probe_hit  (probe_hit),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        pix_valid;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [5:0]  rgb;
    logic        fd;
    logic [15:0] crc;
    logic [5:0]  prgb;
    logic        phit;
    logic [7:0]  err;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Reference model: raster-level view of sync events and lock progress
  int          m_state;
  logic        prev_hs, prev_vs, track_err;
  int          line_len, lines, m_err;
  logic [15:0] m_crc, m_fcrc;
  logic [5:0]  m_prgb;
  exp_t        pipe0, pipe1;

  logic have_prev;
  int   cyc_since_fd, pv_count, fd_seen, ph_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack(input logic [5:0] c, input logic hs, input logic vs);
    logic [7:0] v;
    v[0] = c[5]; v[4] = c[4]; v[1] = c[3]; v[5] = c[2];
    v[2] = c[1]; v[6] = c[0]; v[3] = vs;   v[7] = hs;
    return v;
  endfunction

  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 5; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.crc = 16'hFFFF;
    return e;
  endfunction

  task automatic compare_outputs(input exp_t e);
    check_eq("locked",     32'(locked),     32'(e.locked));
    check_eq("pix_valid",  32'(pix_valid),  32'(e.pix_valid));
    check_eq("frame_done", 32'(frame_done), 32'(e.fd));
    check_eq("frame_crc",  32'(frame_crc),  32'(e.crc));
    check_eq("probe_hit",  32'(probe_hit),  32'(e.phit));
    check_eq("probe_rgb",  32'(probe_rgb),  32'(e.prgb));
    check_eq("err_count",  32'(err_count),  32'(e.err));
    if (e.pix_valid) begin
      check_eq("pix_x", 32'(pix_x), 32'(e.px));
      check_eq("pix_y", 32'(pix_y), 32'(e.py));
      check_eq("rgb",   32'(rgb),   32'(e.rgb));
    end
    if (!locked) have_prev = 1'b0;
    cyc_since_fd++;
    if (pix_valid) pv_count++;
    if (probe_hit) ph_seen++;
    if (frame_done) begin
      fd_seen++;
      if (have_prev) begin
        check_eq("fd_period",    32'(cyc_since_fd), 32'(HT * VT));
        check_eq("pv_per_frame", 32'(pv_count),     32'(HA * VA));
      end
      have_prev    = 1'b1;
      cyc_since_fd = 0;
      pv_count     = 0;
    end
  endtask

  // One pixel clock of raster at (gx, gy); checks the outputs of two cycles ago
  task automatic step(input logic [5:0] col, input int gx, input int gy);
    logic hs, vs, hr, vr, lbad, fbad, ga, fd;
    exp_t e;
    @(negedge clk);
    compare_outputs(pipe1);
    hs = !(gx >= HA + HFP && gx < HA + HFP + HSW);
    vs = !(gy >= VA + VFP && gy < VA + VFP + VSW);
    ga = (gx < HA) && (gy < VA);
    vga_in = pack(ga ? col : 6'd0, hs, vs);

    hr = !prev_hs && hs;
    vr = !prev_vs && vs;
    prev_hs = hs;
    prev_vs = vs;
    lbad = hr && (line_len != HT);
    fbad = vr && (lines != VT);
    if (hr) line_len = 1; else line_len++;
    if (vr) lines = 0; else if (hr) lines++;

    fd = 1'b0;
    case (m_state)
      0: if (vr) begin m_state = 1; track_err = 1'b0; end
      1: begin
        if (lbad) track_err = 1'b1;
        if (vr) begin
          if (!track_err && !fbad) m_state = 2;
          track_err = 1'b0;
        end
      end
      default: begin
        if (lbad || fbad) begin
          m_state = 0;
          if (m_err < 255) m_err++;
        end else if (vr) begin
          fd = 1'b1;
        end
      end
    endcase

    e.locked    = (m_state == 2);
    e.pix_valid = e.locked && ga;
    e.px        = 10'(gx);
    e.py        = 10'(gy);
    e.rgb       = col;
    e.fd        = fd;
`ifdef VGA_CRC_EN
    if (fd) m_fcrc = m_crc;
    if (vr) m_crc = 16'hFFFF;
    else if (e.pix_valid) m_crc = crc_px(m_crc, col);
`endif
    e.crc  = m_fcrc;
    e.phit = e.pix_valid && (10'(gx) == probe_x) && (10'(gy) == probe_y);
    if (e.phit) m_prgb = col;
    e.prgb = m_prgb;
    e.err  = 8'(m_err);
    pipe1 = pipe0;
    pipe0 = e;
  endtask

  // mode: 0 static 110100, 1 random, 2 column index, 3 black, 4 black + one pixel
  task automatic run_frame(input int mode, input int stretch_row);
    logic [5:0] c;
    int fx, fy;
    fx = $urandom_range(HA - 1, 0);
    fy = $urandom_range(VA - 1, 0);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        case (mode)
          0:       c = 6'b110100;
          1:       c = 6'($urandom);
          2:       c = 6'(x);
          4:       c = (x == fx && y == fy) ? 6'b000001 : 6'd0;
          default: c = 6'd0;
        endcase
        step(c, x, y);
        if (y == stretch_row && x == HA) step(c, x, y);
      end
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_locked",    32'(locked),     32'd0);
    check_eq("rst_pix_valid", 32'(pix_valid),  32'd0);
    check_eq("rst_pix_x",     32'(pix_x),      32'd0);
    check_eq("rst_pix_y",     32'(pix_y),      32'd0);
    check_eq("rst_rgb",       32'(rgb),        32'd0);
    check_eq("rst_frame_done",32'(frame_done), 32'd0);
    check_eq("rst_frame_crc", 32'(frame_crc),  32'hFFFF);
    check_eq("rst_probe_rgb", 32'(probe_rgb),  32'd0);
    check_eq("rst_probe_hit", 32'(probe_hit),  32'd0);
    check_eq("rst_err_count", 32'(err_count),  32'd0);
  endtask

  task automatic apply_reset(input logic mid);
    if (mid) begin
      #2 reset = 1'b1;
      #1 check_reset_vals();
    end else begin
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals();
    end
    vga_in = 8'h88;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_state = 0; prev_hs = 1'b1; prev_vs = 1'b1; track_err = 1'b0;
    line_len = 0; lines = 0; m_err = 0;
    m_crc = 16'hFFFF; m_fcrc = 16'hFFFF; m_prgb = 6'd0;
    pipe0 = idle_exp(); pipe1 = idle_exp();
    have_prev = 1'b0; cyc_since_fd = 0; pv_count = 0;
  endtask

  initial begin
    fd_seen = 0;
    ph_seen = 0;
    apply_reset(1'b0);

    // Static colour: lock after the second VSYNC edge, frame_done from the third
    for (int f = 0; f < 5; f++) run_frame(0, -1);
    check_eq("A_locked",  32'(locked), 32'd1);
    check_eq("A_fd_seen", 32'(fd_seen), 32'd3);

    // Random colours with a random in-range probe each frame
    for (int f = 0; f < 3; f++) begin
      probe_x = 10'($urandom_range(HA - 1, 0));
      probe_y = 10'($urandom_range(VA - 1, 0));
      run_frame(1, -1);
    end

    // Probe on a column-index pattern, then an out-of-range column
    probe_x = 10'd10;
    probe_y = 10'd5;
    ph_seen = 0;
    for (int f = 0; f < 2; f++) run_frame(2, -1);
    check_eq("C_probe_rgb",  32'(probe_rgb), 32'd10);
    check_eq("C_probe_hits", 32'(ph_seen),   32'd2);
    probe_x = 10'd700;
    ph_seen = 0;
    for (int f = 0; f < 2; f++) run_frame(2, -1);
    check_eq("C_probe_none", 32'(ph_seen), 32'd0);

    // One line stretched by a clock while locked
    run_frame(1, 3);
    check_eq("D_unlocked", 32'(locked), 32'd0);
    for (int f = 0; f < 3; f++) run_frame(1, -1);
    check_eq("D_relocked", 32'(locked),    32'd1);
    check_eq("D_err",      32'(err_count), 32'd1);

    // Black frames, repeated, then one with a single lit pixel
    run_frame(3, -1);
    run_frame(3, -1);
    run_frame(4, -1);
    run_frame(3, -1);

    // Asynchronous reset part-way through a line while locked
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < HT; x++) step(6'($urandom), x, y);
    end
    for (int x = 0; x < 7; x++) step(6'($urandom), x, 5);
    apply_reset(1'b1);
    for (int f = 0; f < 4; f++) run_frame(1, -1);
    check_eq("F_relocked", 32'(locked),    32'd1);
    check_eq("F_err",      32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
